dmux_bank_reg: RTL and testbench

Bank of three independent registered demultiplexers: 1-to-2, 1-to-4 and 1-to-8. Each channel routes its data input to the output lane named by its select field and drives all other lanes to zero. Outputs are registered on the clock. The block sits between a single producer and several consumers that each need a one-hot-steered copy of the data.

---
 rtl/dmux_bank_reg.sv | 84 ++++++++
 tb/tb_dmux_bank_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmux_bank_reg.sv
// Bank of three registered demultiplexers (1-to-2, 1-to-4, 1-to-8).
// Each channel steers its data to the selected lane and zeroes the rest.

module dmux_chan_reg #(
   parameter int WIDTH = 1,
   parameter int SEL_W = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [WIDTH-1:0]              data,
   input  logic [SEL_W-1:0]              sel,
   input  logic                          en,
   output logic [(1<<SEL_W)*WIDTH-1:0]   lanes
);

   localparam int LANES = 1 << SEL_W;

   logic [LANES-1:0]       lane_hot;
   logic [LANES*WIDTH-1:0] lanes_nxt;

   assign lane_hot = LANES'(1) << sel;

   // Each lane is the data masked by its one-hot select bit.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign lanes_nxt[k*WIDTH +: WIDTH] = {WIDTH{lane_hot[k]}} & data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lanes <= '0;
      end else if (en) begin
         lanes <= lanes_nxt;
      end
   end

endmodule

module dmux_bank_reg #(
   parameter int WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     d2_in,
   input  logic                 d2_sel,
   input  logic                 d2_en,
   output logic [2*WIDTH-1:0]   d2_out,
   input  logic [WIDTH-1:0]     d4_in,
   input  logic [1:0]           d4_sel,
   input  logic                 d4_en,
   output logic [4*WIDTH-1:0]   d4_out,
   input  logic [WIDTH-1:0]     d8_in,
   input  logic [2:0]           d8_sel,
   input  logic                 d8_en,
   output logic [8*WIDTH-1:0]   d8_out
);

   dmux_chan_reg #(.WIDTH(WIDTH), .SEL_W(1)) u_d2 (
      .clk   (clk),
      .rst_n (rst_n),
      .data  (d2_in),
      .sel   (d2_sel),
      .en    (d2_en),
      .lanes (d2_out)
   );

   dmux_chan_reg #(.WIDTH(WIDTH), .SEL_W(2)) u_d4 (
      .clk   (clk),
      .rst_n (rst_n),
      .data  (d4_in),
      .sel   (d4_sel),
      .en    (d4_en),
      .lanes (d4_out)
   );

   dmux_chan_reg #(.WIDTH(WIDTH), .SEL_W(3)) u_d8 (
      .clk   (clk),
      .rst_n (rst_n),
      .data  (d8_in),
      .sel   (d8_sel),
      .en    (d8_en),
      .lanes (d8_out)
   );

endmodule

// File: tb/tb_dmux_bank_reg.sv
// Testbench for dmux_bank_reg: lane-array reference model checked every cycle,
// plus literal spot checks for reset, sweeps, enable hold and mid-run reset.

module tb_dmux_bank_reg;

   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [W-1:0]   d2_in, d4_in, d8_in;
   logic           d2_sel;
   logic [1:0]     d4_sel;
   logic [2:0]     d8_sel;
   logic           d2_en, d4_en, d8_en;
   logic [2*W-1:0] d2_out;
   logic [4*W-1:0] d4_out;
   logic [8*W-1:0] d8_out;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dmux_bank_reg #(.WIDTH(W)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .d2_in  (d2_in),
      .d2_sel (d2_sel),
      .d2_en  (d2_en),
      .d2_out (d2_out),
      .d4_in  (d4_in),
      .d4_sel (d4_sel),
      .d4_en  (d4_en),
      .d4_out (d4_out),
      .d8_in  (d8_in),
      .d8_sel (d8_sel),
      .d8_en  (d8_en),
      .d8_out (d8_out)
   );

   // Reference model: one value per lane.
   logic [W-1:0] m2 [2];
   logic [W-1:0] m4 [4];
   logic [W-1:0] m8 [8];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) m2[i] <= '0;
         for (int i = 0; i < 4; i++) m4[i] <= '0;
         for (int i = 0; i < 8; i++) m8[i] <= '0;
      end else begin
         if (d2_en) for (int i = 0; i < 2; i++) m2[i] <= (i == int'(d2_sel)) ? d2_in : '0;
         if (d4_en) for (int i = 0; i < 4; i++) m4[i] <= (i == int'(d4_sel)) ? d4_in : '0;
         if (d8_en) for (int i = 0; i < 8; i++) m8[i] <= (i == int'(d8_sel)) ? d8_in : '0;
      end
   end

   function automatic logic [31:0] pack2();
      logic [31:0] v = '0;
      for (int i = 0; i < 2; i++) v = v | (32'(m2[i]) << (i*W));
      return v;
   endfunction

   function automatic logic [31:0] pack4();
      logic [31:0] v = '0;
      for (int i = 0; i < 4; i++) v = v | (32'(m4[i]) << (i*W));
      return v;
   endfunction

   function automatic logic [31:0] pack8();
      logic [31:0] v = '0;
      for (int i = 0; i < 8; i++) v = v | (32'(m8[i]) << (i*W));
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("d2_model", 32'(d2_out), pack2());
      check("d4_model", 32'(d4_out), pack4());
      check("d8_model", d8_out, pack8());
   end

   task automatic apply(input logic [W-1:0] i2, input logic s2, input logic e2,
                        input logic [W-1:0] i4, input logic [1:0] s4, input logic e4,
                        input logic [W-1:0] i8, input logic [2:0] s8, input logic e8);
      @(negedge clk);
      d2_in = i2; d2_sel = s2; d2_en = e2;
      d4_in = i4; d4_sel = s4; d4_en = e4;
      d8_in = i8; d8_sel = s8; d8_en = e8;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n  = 1'b0;
      d2_in  = 4'hF; d2_sel = 1'b1;  d2_en = 1'b1;
      d4_in  = 4'hF; d4_sel = 2'd3;  d4_en = 1'b1;
      d8_in  = 4'hF; d8_sel = 3'd7;  d8_en = 1'b1;
      #2;
      check("rst_async_d2", 32'(d2_out), 32'h0);
      check("rst_async_d4", 32'(d4_out), 32'h0);
      check("rst_async_d8", d8_out, 32'h0);

      @(negedge clk);
      d2_en = 1'b0; d4_en = 1'b0; d8_en = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("post_rst_d2", 32'(d2_out), 32'h0);
      check("post_rst_d4", 32'(d4_out), 32'h0);
      check("post_rst_d8", d8_out, 32'h0);

      // 1-to-2 sweep
      for (int in = 0; in < 2; in++)
         for (int s = 0; s < 2; s++) begin
            apply(W'(in), 1'(s), 1'b1, '0, '0, 1'b0, '0, '0, 1'b0);
            check("sweep_d2", 32'(d2_out), 32'(in) << (s*W));
         end
      // 1-to-4 sweep
      for (int in = 0; in < 2; in++)
         for (int s = 0; s < 4; s++) begin
            apply('0, 1'b0, 1'b0, W'(in), 2'(s), 1'b1, '0, '0, 1'b0);
            check("sweep_d4", 32'(d4_out), 32'(in) << (s*W));
         end
      // 1-to-8 sweep
      for (int in = 0; in < 2; in++)
         for (int s = 0; s < 8; s++) begin
            apply('0, 1'b0, 1'b0, '0, '0, 1'b0, W'(in), 3'(s), 1'b1);
            check("sweep_d8", d8_out, 32'(in) << (s*W));
         end

      apply(4'h1, 1'b1, 1'b1, 4'h1, 2'd1, 1'b1, 4'h1, 3'd5, 1'b1);
      check("spot_d2_lane1", 32'(d2_out), 32'h0000_0010);
      check("spot_d4_lane1", 32'(d4_out), 32'h0000_0010);
      check("spot_d8_lane5", d8_out, 32'h0010_0000);
      apply(4'h1, 1'b0, 1'b1, 4'h1, 2'd3, 1'b1, 4'h1, 3'd7, 1'b1);
      check("spot_d2_lane0", 32'(d2_out), 32'h0000_0001);
      check("spot_d4_lane3", 32'(d4_out), 32'h0000_1000);
      check("spot_d8_lane7", d8_out, 32'h1000_0000);
      apply(4'h0, 1'b1, 1'b1, 4'h1, 2'd2, 1'b1, 4'h0, 3'd4, 1'b1);
      check("spot_d2_zero", 32'(d2_out), 32'h0);
      check("spot_d4_lane2", 32'(d4_out), 32'h0000_0100);
      check("spot_d8_zero", d8_out, 32'h0);

      // Enable hold
      apply('0, 1'b0, 1'b0, '0, '0, 1'b0, 4'h1, 3'd3, 1'b1);
      check("hold_load", d8_out, 32'h0000_1000);
      for (int c = 0; c < 3; c++) begin
         apply('0, 1'b0, 1'b0, '0, '0, 1'b0, W'($urandom), 3'($urandom_range(0, 7)), 1'b0);
         check("hold_d8", d8_out, 32'h0000_1000);
      end
      apply('0, 1'b0, 1'b0, '0, '0, 1'b0, 4'h0, 3'd6, 1'b1);
      check("reenable_zero", d8_out, 32'h0);

      // Mid-operation reset between edges
      apply(4'h5, 1'b1, 1'b1, 4'hA, 2'd2, 1'b1, 4'hC, 3'd0, 1'b1);
      check("w4_d2", 32'(d2_out), 32'h0000_0050);
      check("w4_d4", 32'(d4_out), 32'h0000_0A00);
      check("w4_d8", d8_out, 32'h0000_000C);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_d2", 32'(d2_out), 32'h0);
      check("mid_rst_d4", 32'(d4_out), 32'h0);
      check("mid_rst_d8", d8_out, 32'h0);
      @(posedge clk);
      #1;
      check("rst_hold_d4", 32'(d4_out), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic with occasional reset pulses
      for (int c = 0; c < 400; c++) begin
         apply(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               W'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               W'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 39) == 0) begin
            #1 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
